sum_pipe_n: RTL and testbench



---
 rtl/sum_pkg.sv | 13 +
 rtl/sum_chunk.sv | 21 ++
 rtl/sum_pipe_n.sv | 127 ++++++++++++
 tb/tb_sum_pipe_n.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding and
// the two's-complement overflow rule.
package sum_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Overflow when the carry into the MSB differs from the carry out of it.
    function automatic logic ovf_fn(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage

// File: rtl/sum_chunk.sv
// Combinational CHUNK-bit adder slice with carry-out and carry into its MSB.
module sum_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
    assign s    = full[CHUNK-1:0];
    assign cout = full[CHUNK];
    // Carry into the MSB recovered from the MSB sum bit.
    assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/sum_pipe_n.sv
// Pipelined WIDTH-bit adder/subtractor, one carry chunk per stage, with a
// valid/ready handshake and a global stall when the output is blocked.
module sum_pipe_n
    import sum_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if ((STAGES == 0) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("sum_pipe_n: WIDTH must be a non-zero multiple of STAGES");
    end

    localparam int unsigned CHUNK = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtract as a + ~b + !cin; the inverted operand is what gets skewed.
    assign bx = (sub == OP_SUB) ? ~b : b;
    assign c0 = (sub == OP_SUB) ? !cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned LO   = k * CHUNK;
        localparam int unsigned DONE = LO + CHUNK;
        localparam int unsigned REM  = WIDTH - DONE;

        logic [WIDTH-LO-1:0] op_a;
        logic [WIDTH-LO-1:0] op_b;
        logic                ci;
        logic                vin;
        logic [CHUNK-1:0]    cs;
        logic                co;
        logic                cmsb;
        logic [DONE-1:0]     s_d;
        logic                vld_q;
        logic                co_q;
        logic [DONE-1:0]     s_q;

        if (k == 0) begin : g_head
            assign op_a = a;
            assign op_b = bx;
            assign ci   = c0;
            assign vin  = in_valid;
            assign s_d  = cs;
        end else begin : g_tail
            assign op_a = g_stg[k-1].g_skew.a_q;
            assign op_b = g_stg[k-1].g_skew.b_q;
            assign ci   = g_stg[k-1].co_q;
            assign vin  = g_stg[k-1].vld_q;
            assign s_d  = {cs, g_stg[k-1].s_q};
        end

        sum_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (op_a[CHUNK-1:0]),
            .b    (op_b[CHUNK-1:0]),
            .cin  (ci),
            .s    (cs),
            .cout (co),
            .cmsb (cmsb)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                co_q  <= 1'b0;
                s_q   <= '0;
            end else if (adv) begin
                vld_q <= vin;
                co_q  <= co;
                s_q   <= s_d;
            end
        end

        // Upper operand chunks ride along with their beat.
        if (REM > 0) begin : g_skew
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q <= op_a[WIDTH-LO-1:CHUNK];
                    b_q <= op_b[WIDTH-LO-1:CHUNK];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ov_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ov_q <= 1'b0;
                end else if (adv) begin
                    ov_q <= ovf_fn(cmsb, co);
                end
            end

            assign out_valid = vld_q;
            assign sum       = s_q;
            assign cout      = co_q;
            assign ovf       = ov_q;
        end else begin : g_mid
            logic cmsb_unused;
            assign cmsb_unused = cmsb;
        end
    end

endmodule

// File: tb/tb_sum_pipe_n.sv
// Directed bench for sum_pipe_n: 8-bit/2-stage and 16-bit/4-stage instances.
module tb_sum_pipe_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit, 2-stage instance
    logic        iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
    logic [7:0]  a8, b8, s8;
    // 16-bit, 4-stage instance
    logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
    logic [15:0] a16, b16, s16;

    sum_pipe_n #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    sum_pipe_n #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through the 8-bit pipe; latency counts edges from the acceptance edge.
    task automatic send8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s, input logic [7:0] exp_s,
                         input logic exp_c, input logic exp_o);
        int lat;
        a8 = a; b8 = b; cin8 = c; sub8 = s; iv8 = 1'b1; or8 = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(ir8), 32'd1);
        tick();
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " sum"}, 32'(s8), 32'(exp_s));
        check({tag, " cout"}, 32'(co8), 32'(exp_c));
        check({tag, " ovf"}, 32'(of8), 32'(exp_o));
        tick();
    endtask

    task automatic send16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_s, input logic exp_c, input logic exp_o);
        int lat;
        a16 = a; b16 = b; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1; or16 = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(ir16), 32'd1);
        tick();
        iv16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " sum"}, 32'(s16), 32'(exp_s));
        check({tag, " cout"}, 32'(co16), 32'(exp_c));
        check({tag, " ovf"}, 32'(of16), 32'(exp_o));
        tick();
    endtask

    logic [7:0] bp_a   [4] = '{8'd11, 8'd18, 8'd5, 8'd3};
    logic [7:0] bp_b   [4] = '{8'd7,  8'd1,  8'd3, 8'd15};
    logic [7:0] bp_exp [4] = '{8'd18, 8'd19, 8'd8, 8'd18};

    initial begin
        int idx, rcnt, stall;
        bit seen, stray;

        bp_a[3] = 8'd9;
        bp_exp[3] = 8'd24;

        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
        repeat (3) tick();
        check("reset out_valid", 32'(ov8), 32'd0);
        check("reset sum", 32'(s8), 32'd0);
        check("reset cout/ovf", 32'({co8, of8}), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 32'(ir8), 32'd1);

        send8("add 15+15", 8'd15, 8'd15, 1'b0, 1'b0, 8'd30, 1'b0, 1'b0);
        send8("add 200+100", 8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0);
        send8("add 100+100", 8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0, 1'b1);
        send8("sub 9-15", 8'd9, 8'd15, 1'b0, 1'b1, 8'd250, 1'b0, 1'b0);
        send8("sub 18-1-1", 8'd18, 8'd1, 1'b1, 1'b1, 8'd16, 1'b1, 1'b0);
        send8("add ff+1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Back-to-back beats with a 3-cycle consumer stall after the first result.
        idx = 0; rcnt = 0; stall = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 40 && rcnt < 4; cyc++) begin
            if (ov8 && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            or8 = (stall == 0);
            iv8 = (idx < 4);
            if (idx < 4) begin
                a8 = bp_a[idx]; b8 = bp_b[idx]; cin8 = 1'b0; sub8 = 1'b0;
            end
            #1;
            if (ov8 && !or8) begin
                check("stall in_ready", 32'(ir8), 32'd0);
                check("stall sum held", 32'(s8), 32'd18);
            end
            if (ov8 && or8) begin
                check($sformatf("bp result %0d", rcnt), 32'(s8), 32'(bp_exp[rcnt]));
                rcnt++;
            end
            if (iv8 && ir8) idx++;
            if (stall > 0) stall--;
            @(posedge clk);
            #1;
        end
        iv8 = 1'b0; or8 = 1'b1;
        check("bp results count", 32'(rcnt), 32'd4);
        check("bp accepted count", 32'(idx), 32'd4);
        stray = 1'b0;
        repeat (4) begin
            if (ov8) stray = 1'b1;
            tick();
        end
        check("bp no extra beat", 32'(stray), 32'd0);

        // Two beats in flight, then a single reset edge.
        a8 = 8'd1; b8 = 8'd2; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        tick();
        a8 = 8'd3; b8 = 8'd4;
        tick();
        iv8 = 1'b0;
        check("pre-reset out_valid", 32'(ov8), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid reset out_valid", 32'(ov8), 32'd0);
        check("mid reset sum", 32'(s8), 32'd0);
        #1;
        check("mid reset in_ready", 32'(ir8), 32'd1);
        stray = 1'b0;
        repeat (5) begin
            if (ov8) stray = 1'b1;
            tick();
        end
        check("no stale beat", 32'(stray), 32'd0);

        send16("w16 ffff+1", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        send16("w16 7fff+1", 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
